// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Holds the response FSM states, default memory depth and port indices.
package dmem_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD0,
      RD1,
      ERR0,
      ERR1
   } dmem_state_t;

   localparam int DMEM_WORDS_DEFAULT = 32;

   localparam int PORT0 = 0;
   localparam int PORT1 = 1;

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way winner selection for the data-memory arbiter.
// pointer names the port granted last; mode 1 makes port 0 always win.
module dmem_rr_pick
   import dmem_pkg::*;
(
   input  logic [1:0] req,
   input  logic       pointer,
   input  logic       mode,
   output logic [1:0] grant
);

   // one-hot grant; a lone requester wins regardless of the pointer
   always_comb begin
      grant = 2'b00;
      if (req[PORT0] && req[PORT1]) begin
         if (mode || pointer)
            grant[PORT0] = 1'b1;
         else
            grant[PORT1] = 1'b1;
      end else begin
         grant = req;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-ported data memory.
// Port 0 is the MEM stage, port 1 the loader/debug path.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int DMEM_WORDS    = DMEM_WORDS_DEFAULT,
   parameter int PRIORITY_MODE = 0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        p0_req,
   input  logic        p0_we,
   input  logic [31:0] p0_addr,
   input  logic [31:0] p0_wdata,
   output logic        p0_gnt,
   output logic        p0_rvalid,
   output logic [31:0] p0_rdata,
   output logic        p0_err,
   input  logic        p1_req,
   input  logic        p1_we,
   input  logic [31:0] p1_addr,
   input  logic [31:0] p1_wdata,
   output logic        p1_gnt,
   output logic        p1_rvalid,
   output logic [31:0] p1_rdata,
   output logic        p1_err,
   output logic        mem_write,
   output logic        mem_read,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_result
);

   logic [1:0]  req;
   logic [1:0]  pick;
   logic [1:0]  gnt;
   logic        last_gnt;
   logic        any_gnt;
   logic        win;
   logic        win_we;
   logic [31:0] win_addr;
   logic [31:0] win_wdata;
   logic        in_range;
   logic        hit;
   logic        live;
   dmem_state_t state;

   assign req = {p1_req, p0_req};

   dmem_rr_pick u_pick (
      .req     (req),
      .pointer (last_gnt),
      .mode    (PRIORITY_MODE != 0),
      .grant   (pick)
   );

   assign gnt    = reset ? 2'b00 : pick;
   assign p0_gnt = gnt[PORT0];
   assign p1_gnt = gnt[PORT1];

   assign any_gnt   = |gnt;
   assign win       = gnt[PORT1];
   assign win_we    = win ? p1_we    : p0_we;
   assign win_addr  = win ? p1_addr  : p0_addr;
   assign win_wdata = win ? p1_wdata : p0_wdata;
   assign in_range  = win_addr < 32'(DMEM_WORDS);
   assign hit       = any_gnt && in_range;

   assign mem_write      = hit && win_we;
   assign mem_read       = hit && !win_we;
   assign mem_address    = hit ? win_addr  : '0;
   assign mem_write_data = hit ? win_wdata : '0;

   // response state follows the access granted this cycle; pointer tracks last winner
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         last_gnt <= 1'b1;
      end else begin
         if (any_gnt)
            last_gnt <= win;
         if (!any_gnt)
            state <= IDLE;
         else if (!in_range)
            state <= win ? ERR1 : ERR0;
         else if (!win_we)
            state <= win ? RD1 : RD0;
         else
            state <= IDLE;
      end
   end

   // a response in flight is dropped as soon as reset is seen
   assign live = !reset;

   assign p0_rvalid = live && (state == RD0 || state == ERR0);
   assign p1_rvalid = live && (state == RD1 || state == ERR1);
   assign p0_err    = live && (state == ERR0);
   assign p1_err    = live && (state == ERR1);
   assign p0_rdata  = (live && state == RD0) ? mem_result : '0;
   assign p1_rdata  = (live && state == RD1) ? mem_result : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a round-robin instance with a memory
// model and a fixed-priority instance sharing the same request inputs.
module tb_dmem_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic        p0_req, p0_we, p1_req, p1_we;
   logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;

   logic        r_p0_gnt, r_p0_rvalid, r_p0_err;
   logic        r_p1_gnt, r_p1_rvalid, r_p1_err;
   logic [31:0] r_p0_rdata, r_p1_rdata;
   logic        r_mem_write, r_mem_read;
   logic [31:0] r_mem_address, r_mem_write_data;
   logic [31:0] r_mem_result;

   logic        f_p0_gnt, f_p0_rvalid, f_p0_err;
   logic        f_p1_gnt, f_p1_rvalid, f_p1_err;
   logic [31:0] f_p0_rdata, f_p1_rdata;
   logic        f_mem_write, f_mem_read;
   logic [31:0] f_mem_address, f_mem_write_data;
   logic [31:0] f_mem_result;

   logic [31:0] mem [0:31];

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   dmem_arbiter #(.DMEM_WORDS(32), .PRIORITY_MODE(0)) dut (
      .clock(clock), .reset(reset),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr),
      .p0_wdata(p0_wdata), .p0_gnt(r_p0_gnt), .p0_rvalid(r_p0_rvalid),
      .p0_rdata(r_p0_rdata), .p0_err(r_p0_err),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr),
      .p1_wdata(p1_wdata), .p1_gnt(r_p1_gnt), .p1_rvalid(r_p1_rvalid),
      .p1_rdata(r_p1_rdata), .p1_err(r_p1_err),
      .mem_write(r_mem_write), .mem_read(r_mem_read),
      .mem_address(r_mem_address), .mem_write_data(r_mem_write_data),
      .mem_result(r_mem_result)
   );

   dmem_arbiter #(.DMEM_WORDS(32), .PRIORITY_MODE(1)) dut_fx (
      .clock(clock), .reset(reset),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr),
      .p0_wdata(p0_wdata), .p0_gnt(f_p0_gnt), .p0_rvalid(f_p0_rvalid),
      .p0_rdata(f_p0_rdata), .p0_err(f_p0_err),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr),
      .p1_wdata(p1_wdata), .p1_gnt(f_p1_gnt), .p1_rvalid(f_p1_rvalid),
      .p1_rdata(f_p1_rdata), .p1_err(f_p1_err),
      .mem_write(f_mem_write), .mem_read(f_mem_read),
      .mem_address(f_mem_address), .mem_write_data(f_mem_write_data),
      .mem_result(f_mem_result)
   );

   assign f_mem_result = 32'h0;

   // memory model: word i holds i after reset, registered read port
   always @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 32; i++)
            mem[i] <= i;
         r_mem_result <= 32'h0;
      end else begin
         if (r_mem_write)
            mem[r_mem_address[4:0]] <= r_mem_write_data;
         if (r_mem_read)
            r_mem_result <= mem[r_mem_address[4:0]];
      end
   end

   task automatic set_idle();
      p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
      p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1;
      set_idle();
      @(negedge clock);
      @(negedge clock);
      reset = 0;
   endtask

   task automatic test_reset();
      @(negedge clock);
      reset = 1;
      set_idle();
      p0_req = 1; p0_we = 1; p0_addr = 3; p0_wdata = 32'h55;
      p1_req = 1; p1_addr = 4;
      #1;
      checks++;
      if (r_p0_gnt !== 0 || r_p1_gnt !== 0) begin
         errors++;
         $display("FAIL reset_gnt got %b%b want 00", r_p1_gnt, r_p0_gnt);
      end
      checks++;
      if (r_mem_write !== 0 || r_mem_read !== 0) begin
         errors++;
         $display("FAIL reset_mem got w=%b r=%b want 0 0",
                  r_mem_write, r_mem_read);
      end
      @(negedge clock);
      set_idle();
      @(negedge clock);
      reset = 0;
      #1;
      checks++;
      if ({r_p0_gnt, r_p0_rvalid, r_p0_err, r_p1_gnt, r_p1_rvalid,
           r_p1_err, r_mem_write, r_mem_read} !== 8'h00 ||
          r_p0_rdata !== 0 || r_p1_rdata !== 0 ||
          r_mem_address !== 0 || r_mem_write_data !== 0) begin
         errors++;
         $display("FAIL post_reset_outputs got nonzero want all 0");
      end
   endtask

   task automatic test_single_read();
      @(negedge clock);
      p0_req = 1; p0_we = 0; p0_addr = 5;
      #1;
      checks++;
      if (r_p0_gnt !== 1 || r_p1_gnt !== 0 || r_mem_read !== 1 ||
          r_mem_write !== 0 || r_mem_address !== 5) begin
         errors++;
         $display("FAIL single_read_req got g=%b%b r=%b a=%0d want 01 1 5",
                  r_p1_gnt, r_p0_gnt, r_mem_read, r_mem_address);
      end
      @(negedge clock);
      set_idle();
      #1;
      checks++;
      if (r_p0_rvalid !== 1 || r_p0_rdata !== 5 || r_p0_err !== 0) begin
         errors++;
         $display("FAIL single_read_rsp got v=%b d=%0d e=%b want 1 5 0",
                  r_p0_rvalid, r_p0_rdata, r_p0_err);
      end
      checks++;
      if (r_p1_rvalid !== 0 || r_p1_rdata !== 0) begin
         errors++;
         $display("FAIL single_read_other got v=%b d=%h want 0 0",
                  r_p1_rvalid, r_p1_rdata);
      end
      @(negedge clock);
      #1;
      checks++;
      if (r_p0_rvalid !== 0 || r_mem_read !== 0 || r_mem_address !== 0) begin
         errors++;
         $display("FAIL idle_after_read got v=%b r=%b a=%0d want 0 0 0",
                  r_p0_rvalid, r_mem_read, r_mem_address);
      end
   endtask

   task automatic test_rr_conflict();
      logic exp_p1;
      do_reset();
      for (int k = 0; k < 5; k++) begin
         @(negedge clock);
         if (k < 4) begin
            p0_req = 1; p0_we = 0; p0_addr = 1;
            p1_req = 1; p1_we = 0; p1_addr = 2;
         end else begin
            set_idle();
         end
         #1;
         if (k < 4) begin
            exp_p1 = (k % 2) == 1;
            checks++;
            if (r_p0_gnt !== !exp_p1 || r_p1_gnt !== exp_p1) begin
               errors++;
               $display("FAIL rr_grant_%0d got %b%b want %b%b", k,
                        r_p1_gnt, r_p0_gnt, exp_p1, !exp_p1);
            end
         end
         if (k > 0) begin
            exp_p1 = ((k - 1) % 2) == 1;
            checks++;
            if (exp_p1 ? (r_p1_rvalid !== 1 || r_p1_rdata !== 2 ||
                          r_p0_rvalid !== 0 || r_p0_rdata !== 0)
                       : (r_p0_rvalid !== 1 || r_p0_rdata !== 1 ||
                          r_p1_rvalid !== 0 || r_p1_rdata !== 0)) begin
               errors++;
               $display("FAIL rr_rsp_%0d got v=%b%b d0=%0d d1=%0d", k,
                        r_p1_rvalid, r_p0_rvalid, r_p0_rdata, r_p1_rdata);
            end
         end
      end
   endtask

   task automatic test_fixed();
      do_reset();
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         p0_req = (k < 3); p0_we = 0; p0_addr = 8;
         p1_req = 1;       p1_we = 0; p1_addr = 9;
         #1;
         checks++;
         if (f_p0_gnt !== (k < 3) || f_p1_gnt !== (k == 3)) begin
            errors++;
            $display("FAIL fixed_grant_%0d got %b%b want %b%b", k,
                     f_p1_gnt, f_p0_gnt, k == 3, k < 3);
         end
      end
      @(negedge clock);
      set_idle();
   endtask

   task automatic test_write_read();
      @(negedge clock);
      set_idle();
      p1_req = 1; p1_we = 1; p1_addr = 7; p1_wdata = 32'hDEADBEEF;
      #1;
      checks++;
      if (r_p1_gnt !== 1 || r_mem_write !== 1 || r_mem_read !== 0 ||
          r_mem_address !== 7 || r_mem_write_data !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL write_req got g=%b w=%b a=%0d d=%h want 1 1 7 deadbeef",
                  r_p1_gnt, r_mem_write, r_mem_address, r_mem_write_data);
      end
      @(negedge clock);
      set_idle();
      p0_req = 1; p0_we = 0; p0_addr = 7;
      #1;
      checks++;
      if (r_p0_gnt !== 1 || r_mem_read !== 1 || r_p1_rvalid !== 0) begin
         errors++;
         $display("FAIL wr_then_rd_req got g=%b r=%b p1v=%b want 1 1 0",
                  r_p0_gnt, r_mem_read, r_p1_rvalid);
      end
      @(negedge clock);
      set_idle();
      #1;
      checks++;
      if (r_p0_rvalid !== 1 || r_p0_rdata !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL wr_then_rd_rsp got v=%b d=%h want 1 deadbeef",
                  r_p0_rvalid, r_p0_rdata);
      end
   endtask

   task automatic test_out_of_range();
      @(negedge clock);
      set_idle();
      p0_req = 1; p0_we = 0; p0_addr = 40;
      #1;
      checks++;
      if (r_p0_gnt !== 1 || r_mem_read !== 0 || r_mem_write !== 0) begin
         errors++;
         $display("FAIL oor_read_req got g=%b r=%b w=%b want 1 0 0",
                  r_p0_gnt, r_mem_read, r_mem_write);
      end
      @(negedge clock);
      set_idle();
      p1_req = 1; p1_we = 1; p1_addr = 32; p1_wdata = 32'h1234;
      #1;
      checks++;
      if (r_p0_rvalid !== 1 || r_p0_err !== 1 || r_p0_rdata !== 0) begin
         errors++;
         $display("FAIL oor_read_rsp got v=%b e=%b d=%h want 1 1 0",
                  r_p0_rvalid, r_p0_err, r_p0_rdata);
      end
      checks++;
      if (r_p1_gnt !== 1 || r_mem_write !== 0) begin
         errors++;
         $display("FAIL oor_write_req got g=%b w=%b want 1 0",
                  r_p1_gnt, r_mem_write);
      end
      @(negedge clock);
      set_idle();
      p0_req = 1; p0_we = 0; p0_addr = 31;
      #1;
      checks++;
      if (r_p1_rvalid !== 1 || r_p1_err !== 1 || r_p1_rdata !== 0) begin
         errors++;
         $display("FAIL oor_write_rsp got v=%b e=%b d=%h want 1 1 0",
                  r_p1_rvalid, r_p1_err, r_p1_rdata);
      end
      checks++;
      if (r_mem_read !== 1 || r_mem_address !== 31) begin
         errors++;
         $display("FAIL top_addr_req got r=%b a=%0d want 1 31",
                  r_mem_read, r_mem_address);
      end
      @(negedge clock);
      set_idle();
      #1;
      checks++;
      if (r_p0_rvalid !== 1 || r_p0_err !== 0 || r_p0_rdata !== 31) begin
         errors++;
         $display("FAIL top_addr_rsp got v=%b e=%b d=%0d want 1 0 31",
                  r_p0_rvalid, r_p0_err, r_p0_rdata);
      end
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         set_idle();
         if (k < 3) begin
            p0_req = 1; p0_we = 0; p0_addr = 10 + k;
         end
         #1;
         if (k < 3) begin
            checks++;
            if (r_p0_gnt !== 1 || r_mem_address !== 10 + k) begin
               errors++;
               $display("FAIL b2b_req_%0d got g=%b a=%0d want 1 %0d", k,
                        r_p0_gnt, r_mem_address, 10 + k);
            end
         end
         if (k > 0) begin
            checks++;
            if (r_p0_rvalid !== 1 || r_p0_rdata !== 9 + k) begin
               errors++;
               $display("FAIL b2b_rsp_%0d got v=%b d=%0d want 1 %0d", k,
                        r_p0_rvalid, r_p0_rdata, 9 + k);
            end
         end
      end
   endtask

   task automatic test_reset_mid_read();
      do_reset();
      @(negedge clock);
      p1_req = 1; p1_we = 0; p1_addr = 3;
      #1;
      checks++;
      if (r_p1_gnt !== 1 || r_mem_read !== 1) begin
         errors++;
         $display("FAIL mid_rst_req got g=%b r=%b want 1 1",
                  r_p1_gnt, r_mem_read);
      end
      @(negedge clock);
      set_idle();
      reset = 1;
      #1;
      checks++;
      if (r_p1_rvalid !== 0 || r_p1_rdata !== 0) begin
         errors++;
         $display("FAIL mid_rst_rvalid got v=%b d=%h want 0 0",
                  r_p1_rvalid, r_p1_rdata);
      end
      @(negedge clock);
      reset = 0;
      #1;
      checks++;
      if (r_p1_rvalid !== 0) begin
         errors++;
         $display("FAIL mid_rst_after got v=%b want 0", r_p1_rvalid);
      end
      @(negedge clock);
      p0_req = 1; p0_we = 0; p0_addr = 4;
      p1_req = 1; p1_we = 0; p1_addr = 6;
      #1;
      checks++;
      if (r_p0_gnt !== 1 || r_p1_gnt !== 0) begin
         errors++;
         $display("FAIL mid_rst_conflict got %b%b want 01",
                  r_p1_gnt, r_p0_gnt);
      end
      @(negedge clock);
      set_idle();
   endtask

   initial begin
      reset = 1;
      set_idle();
      repeat (2) @(negedge clock);
      test_reset();
      test_single_read();
      test_rr_conflict();
      test_fixed();
      test_write_read();
      test_out_of_range();
      test_back_to_back();
      test_reset_mid_read();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
